// File: rtl/pwm_duty_meter_pkg.sv
// Shared types and elaboration-time parameter checks for the PWM duty meter.
package pwm_meter_pkg;

   // IDLE: no reference rising edge yet; MEAS: counting since the last rise.
   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   localparam int TIMEOUT_MIN = 2;
   localparam int SYNC_MIN    = 1;
   localparam int SYNC_MAX    = 4;

   // TIMEOUT must fit the counters so per_cnt can never wrap.
   function automatic bit timeout_ok(input int timeout, input int cnt_w);
      return (timeout >= TIMEOUT_MIN) &&
             (longint'(timeout) <= ((longint'(1) << cnt_w) - 1));
   endfunction

   function automatic bit sync_ok(input int stages);
      return (stages >= SYNC_MIN) && (stages <= SYNC_MAX);
   endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Bundle of the PWM input and the measurement/flag outputs.
// master: drives pwm_in and observes results; slave: the meter itself.
interface pwm_duty_meter_if #(
   parameter int CNT_W = 16
);
   logic             pwm_in;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;

   modport master (
      output pwm_in,
      input  period_cnt, high_cnt, meas_valid, stuck_high, stuck_low
   );

   modport slave (
      input  pwm_in,
      output period_cnt, high_cnt, meas_valid, stuck_high, stuck_low
   );
endinterface

// File: rtl/pwm_duty_meter_sync.sv
// Multi-stage synchroniser for the asynchronous PWM line plus a one-cycle
// delayed copy used to detect rising edges.
module pwm_in_sync
   import pwm_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pwm,
   output logic o_s,
   output logic o_rise
);

   if (!sync_ok(SYNC_STAGES)) begin : g_bad_sync
      $error("pwm_in_sync: SYNC_STAGES must be in 1..4");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= i_pwm;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   // Keep the previous synchronised sample for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_d <= 1'b0;
      end else begin
         r_s_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_s    = r_sync[SYNC_STAGES-1];
   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures rise-to-rise period and high time of each PWM
// cycle, publishes one result per completed period and flags a line that
// has stopped toggling (stuck high or stuck low).
module pwm_duty_meter
   import pwm_meter_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   pwm_duty_meter_if.slave    bus
);

   if (!timeout_ok(TIMEOUT, CNT_W)) begin : g_bad_timeout
      $error("pwm_duty_meter: TIMEOUT must be in 2..2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_per_cnt;
   logic [CNT_W-1:0] r_hi_cnt;
   logic [CNT_W-1:0] r_idle_cnt;
   logic [CNT_W-1:0] r_period_cnt;
   logic [CNT_W-1:0] r_high_cnt;
   logic             r_meas_valid;
   logic             r_stuck_high;
   logic             r_stuck_low;
   logic             w_s;
   logic             w_rise;
   logic             w_timeout_hit;

   pwm_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_pwm  (bus.pwm_in),
      .o_s    (w_s),
      .o_rise (w_rise)
   );

   // A rise always wins over the timeout; the timeout fires on the cycle
   // the idle counter steps onto TIMEOUT.
   assign w_timeout_hit = !w_rise && (r_idle_cnt == TIMEOUT_M1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state: any rise (re)arms, a timeout drops back to IDLE.
   always_comb begin
      w_state_next = r_state;
      if (w_rise) begin
         w_state_next = MEAS;
      end else if (w_timeout_hit) begin
         w_state_next = IDLE;
      end
   end

   // Period and high-time counters; the rise cycle itself counts as one high cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_per_cnt <= '0;
         r_hi_cnt  <= '0;
      end else if (w_rise) begin
         r_per_cnt <= ONE_C;
         r_hi_cnt  <= ONE_C;
      end else if (r_state == MEAS) begin
         r_per_cnt <= r_per_cnt + ONE_C;
         if (w_s) begin
            r_hi_cnt <= r_hi_cnt + ONE_C;
         end
      end
   end

   // Cycles since the last rise (or reset), saturating at TIMEOUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle_cnt <= '0;
      end else if (w_rise) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != TIMEOUT_C) begin
         r_idle_cnt <= r_idle_cnt + ONE_C;
      end
   end

   // Publish results on a rise while measuring, and manage the stuck flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_period_cnt <= '0;
         r_high_cnt   <= '0;
         r_meas_valid <= 1'b0;
         r_stuck_high <= 1'b0;
         r_stuck_low  <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         if (w_rise) begin
            if (r_state == MEAS) begin
               r_period_cnt <= r_per_cnt;
               r_high_cnt   <= r_hi_cnt;
               r_meas_valid <= 1'b1;
            end
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
         end else if (w_timeout_hit) begin
            r_stuck_high <= w_s;
            r_stuck_low  <= ~w_s;
         end
      end
   end

   assign bus.period_cnt = r_period_cnt;
   assign bus.high_cnt   = r_high_cnt;
   assign bus.meas_valid = r_meas_valid;
   assign bus.stuck_high = r_stuck_high;
   assign bus.stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed testbench for pwm_duty_meter: instance A uses TIMEOUT=1024,
// instance B uses TIMEOUT=16. Inputs change on the falling edge; outputs
// are checked on the falling edge.
module tb_pwm_duty_meter;

   localparam int CNT_W   = 16;
   localparam int TO_A    = 1024;
   localparam int TO_B    = 16;

   logic clk;
   logic rst;

   int tests;
   int fails;
   int b_pulses;

   logic [CNT_W-1:0] q_per[$];
   logic [CNT_W-1:0] q_hi[$];

   pwm_duty_meter_if #(.CNT_W(CNT_W)) bus_a ();
   pwm_duty_meter_if #(.CNT_W(CNT_W)) bus_b ();

   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_A), .SYNC_STAGES(2)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_B), .SYNC_STAGES(2)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every published measurement of instance A.
   always @(negedge clk) begin
      if (bus_a.meas_valid === 1'b1) begin
         q_per.push_back(bus_a.period_cnt);
         q_hi.push_back(bus_a.high_cnt);
      end
   end

   // Count publish pulses of instance B.
   always @(negedge clk) begin
      if (bus_b.meas_valid === 1'b1) b_pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_meas(input string tag, input int per, input int hi);
      logic [31:0] p;
      logic [31:0] h;
      chk({tag, "_avail"}, 32'(q_per.size() != 0), 32'd1);
      if (q_per.size() != 0) begin
         p = 32'(q_per.pop_front());
         h = 32'(q_hi.pop_front());
         chk({tag, "_per"}, p, per);
         chk({tag, "_hi"}, h, hi);
      end
   endtask

   task automatic expect_none(input string tag);
      chk({tag, "_none"}, 32'(q_per.size()), 32'd0);
   endtask

   // Hold a level on instance A (sel=0) or B (sel=1) for n cycles.
   task automatic drive(input bit sel, input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) bus_b.pwm_in = lvl;
         else     bus_a.pwm_in = lvl;
         @(negedge clk);
      end
   endtask

   task automatic period_a(input int hi, input int per);
      drive(1'b0, 1'b1, hi);
      drive(1'b0, 1'b0, per - hi);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      b_pulses = 0;
      rst          = 1'b1;
      bus_a.pwm_in = 1'b0;
      bus_b.pwm_in = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_period", 32'(bus_a.period_cnt), 0);
      chk("rst_high", 32'(bus_a.high_cnt), 0);
      chk("rst_valid", 32'(bus_a.meas_valid), 0);
      chk("rst_stuck_h", 32'(bus_a.stuck_high), 0);
      chk("rst_stuck_l", 32'(bus_a.stuck_low), 0);
      rst = 1'b0;

      // Line held low: stuck_low exactly TIMEOUT cycles after reset release.
      drive(1'b0, 1'b0, TO_A - 1);
      chk("slow_before", 32'(bus_a.stuck_low), 0);
      drive(1'b0, 1'b0, 1);
      chk("slow_at", 32'(bus_a.stuck_low), 1);
      chk("slow_sh", 32'(bus_a.stuck_high), 0);
      drive(1'b0, 1'b0, 1100 - TO_A);
      chk("slow_hold", 32'(bus_a.stuck_low), 1);
      expect_none("slow");

      // First rise clears the flag and only arms.
      period_a(5, 10);
      chk("slow_clear", 32'(bus_a.stuck_low), 0);
      expect_none("arm");

      // 50% duty, 10-cycle period.
      for (int i = 0; i < 4; i++) period_a(5, 10);
      for (int i = 0; i < 4; i++) expect_meas("d50", 10, 5);
      expect_none("d50");
      chk("d50_sh", 32'(bus_a.stuck_high), 0);
      chk("d50_sl", 32'(bus_a.stuck_low), 0);

      // Duty steps 6, 9, 1 (first publish is the last 50% period).
      for (int i = 0; i < 3; i++) period_a(6, 10);
      for (int i = 0; i < 3; i++) period_a(9, 10);
      for (int i = 0; i < 3; i++) period_a(1, 10);
      expect_meas("step5", 10, 5);
      for (int i = 0; i < 3; i++) expect_meas("step6", 10, 6);
      for (int i = 0; i < 3; i++) expect_meas("step9", 10, 9);
      for (int i = 0; i < 2; i++) expect_meas("step1", 10, 1);
      expect_none("step");

      // Duty 9 then held high: stuck_high TIMEOUT cycles after the last rise.
      for (int i = 0; i < 9; i++) period_a(9, 10);
      drive(1'b0, 1'b1, TO_A + 2);
      chk("shigh_before", 32'(bus_a.stuck_high), 0);
      drive(1'b0, 1'b1, 1);
      chk("shigh_at", 32'(bus_a.stuck_high), 1);
      chk("shigh_sl", 32'(bus_a.stuck_low), 0);
      expect_meas("d9_tail1", 10, 1);
      for (int i = 0; i < 9; i++) expect_meas("d9", 10, 9);
      expect_none("d9");

      // Resume 50%: first rise clears without publishing, next ones publish.
      drive(1'b0, 1'b0, 5);
      period_a(5, 10);
      chk("shigh_clear", 32'(bus_a.stuck_high), 0);
      expect_none("resume_arm");
      period_a(5, 10);
      period_a(5, 10);
      expect_meas("resume", 10, 5);
      expect_meas("resume", 10, 5);
      expect_none("resume");

      // Asynchronous reset in the low phase of a period.
      drive(1'b0, 1'b1, 5);
      drive(1'b0, 1'b0, 2);
      expect_meas("pre_rst", 10, 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_period", 32'(bus_a.period_cnt), 0);
      chk("arst_high", 32'(bus_a.high_cnt), 0);
      chk("arst_valid", 32'(bus_a.meas_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 2);
      period_a(5, 10);
      expect_none("arst_arm");
      period_a(5, 10);
      period_a(5, 10);
      expect_meas("arst", 10, 5);
      expect_meas("arst", 10, 5);
      expect_none("arst");

      // TIMEOUT=16 with 20-cycle period: flag set mid low phase, cleared at each rise.
      for (int p = 0; p < 3; p++) begin
         drive(1'b1, 1'b1, 2);
         chk("b_sl_prev", 32'(bus_b.stuck_low), 1);
         drive(1'b1, 1'b1, 1);
         chk("b_sl_clear", 32'(bus_b.stuck_low), 0);
         drive(1'b1, 1'b1, 7);
         drive(1'b1, 1'b0, 5);
         chk("b_sl_mid", 32'(bus_b.stuck_low), 0);
         drive(1'b1, 1'b0, 3);
         chk("b_sl_pre", 32'(bus_b.stuck_low), 0);
         drive(1'b1, 1'b0, 1);
         chk("b_sl_set", 32'(bus_b.stuck_low), 1);
         chk("b_sh", 32'(bus_b.stuck_high), 0);
         drive(1'b1, 1'b0, 1);
      end
      chk("b_no_valid", 32'(b_pulses), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
